pulse_train_sequencer: RTL and testbench
========================================

# pulse_train_sequencer

Sequences the pulse generator in the user project from the logic-analyzer (LA) control bits. The management core serially loads a period/high-time/count word over two LA bits, then triggers a run. The block emits a pulse train of `COUNT` pulses, or runs continuously, and reports busy, done and error status. It sits between the LA inputs and the pulse output pin, clocked by the Wishbone clock.

## Interface

Parameters:
- `CNT_W`, 16: width of the PERIOD and HIGH fields and of the phase counter.
- `NUM_W`, 8: width of the COUNT field and the remaining-pulse counter.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  reset; synchronous, active-high.
- `la_data_in`  in  5  LA control bits: [0] serial data, [1] shift strobe, [2] start, [3] abort, [4] continuous mode.
- `la_oenb`  in  5  LA output-enable-bar. Bit i is effective only when `la_oenb[i]`=0; effective bit = `la_data_in[i] & ~la_oenb[i]`.
- `pulse_o`  out  1  pulse train output.
- `busy_o`  out  1  high while a run is in progress.
- `done_o`  out  1  one-cycle strobe at normal run completion.
- `err_o`  out  1  sticky flag: last start carried an invalid config.
- `remain_o`  out  NUM_W  pulses remaining, including the current one.

## Operation

- **Config load.** A rising edge of effective bit [1] shifts `sr <= {sr[SR_W-2:0], bit0}`, where `SR_W = 2*CNT_W+NUM_W`.
  - Layout, MSB first: `{PERIOD, HIGH, COUNT}`.
  - The shift register is independent of a running train. It may be reloaded while busy, and the active run is unaffected.
- **Start.** A rising edge of effective bit [2] in IDLE validates `sr`.
  - Valid means: HIGH≥1, PERIOD>HIGH, and COUNT≥1 (or continuous mode is on).
  - Valid: latch the fields into active registers, set `remain_o`=COUNT, clear `err_o`, enter HIGH.
  - Invalid: set `err_o` and stay in IDLE.
  - A start edge while busy is ignored.
- **FSM states.**
  - IDLE: `pulse_o`=0, `busy_o`=0.
  - HIGH: `pulse_o`=1 for HIGH cycles, then go to LOW.
  - LOW: `pulse_o`=0 for PERIOD−HIGH cycles. At the end, if `remain_o`>1 or continuous mode is on, decrement `remain_o` (not decremented in continuous mode) and go to HIGH. Otherwise go to IDLE and assert `done_o` for 1 cycle.
- **Abort.** Effective bit [3] is level-sensitive. When high, the next state is IDLE from any state. `pulse_o` falls the next cycle, `done_o` is not asserted, and `remain_o` holds its last value.
- **Continuous mode.** Bit [4] is sampled at start and latched for the whole run. COUNT is ignored when it is set.
- **Phase counter.** Single counter of CNT_W bits. Loads terminal count −1 on phase entry and counts down to 0; no wrap.

## Timing

- Reset values: `pulse_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0, `remain_o`=0, `sr`=0, active registers=0, state=IDLE.
- Edge detection: registered previous value. An edge is seen in cycle N when the bit is 1 at N and was 0 at N−1.
- Start latency: start edge seen at cycle N gives `pulse_o`=1 and `busy_o`=1 from cycle N+1.
- Exact period: `pulse_o` is high for exactly HIGH cycles and low for exactly PERIOD−HIGH cycles. Pulse k rises at N+1+k·PERIOD.
- Completion: `done_o` is high in the cycle after the last LOW cycle, and `busy_o` is 0 in that same cycle.
- Simultaneous events:
  - Abort beats start in the same cycle.
  - Shift and start in the same cycle: the start validates the pre-shift `sr`.
- Reset during a run: IDLE on the next edge with all outputs at reset values. `sr` is cleared.

## Configuration

- Macro `PULSE_SEQ_CONT_EN`.
- Defined: continuous mode is supported as described above.
- Undefined: LA bit [4] is ignored, the continuous latch is removed, and COUNT=0 is always invalid.

## Structure

- Package `pulse_seq_pkg` holds:
  - the state enum (IDLE, HIGH, LOW);
  - LA bit index constants (DATA=0, SHIFT=1, START=2, ABORT=3, CONT=4);
  - field offset and width localparams for the config word.
- Sub-module `la_edge_det`: masks one LA bit with its `la_oenb` bit and produces a registered-previous rising-edge strobe. Instantiated for bits 1 and 2.

## Test plan

- Shift in PERIOD=10, HIGH=3, COUNT=4, then start → 4 pulses, each 3 cycles high and 7 low, rising at N+1, N+11, N+21, N+31. `done_o` at N+41, `remain_o` goes 4,3,2,1.
- Load HIGH=5, PERIOD=5, then start → `err_o`=1, `busy_o` stays 0. A following valid start clears `err_o`.
- Abort asserted during the 2nd pulse's HIGH phase → `pulse_o`=0 and `busy_o`=0 next cycle, no `done_o`.
- Continuous mode with PERIOD=4, HIGH=1 → run 100 cycles with no `done_o`. Abort stops the train. With the macro undefined, the same load with COUNT=0 gives `err_o`.
- `la_oenb`=5'h1F while toggling `la_data_in` → no shift, no start, outputs stay at reset values.
- Start, then reload `sr` mid-run with PERIOD=20 → current run keeps PERIOD=10. The next start uses 20.

Source files
------------

// File: rtl/pulse_train_sequencer_pkg.sv
// pulse_seq_pkg: FSM states, LA bit indices and config-word layout for the pulse train sequencer
package pulse_seq_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;
  localparam int LA_W  = 5;
  localparam int DATA  = 0;
  localparam int SHIFT = 1;
  localparam int START = 2;
  localparam int ABORT = 3;
  localparam int CONT  = 4;
  localparam int COUNT_LSB = 0;
  function automatic int high_lsb(input int num_w);
    return num_w;
  endfunction
  function automatic int period_lsb(input int cnt_w, input int num_w);
    return num_w + cnt_w;
  endfunction
  function automatic int sr_width(input int cnt_w, input int num_w);
    return 2 * cnt_w + num_w;
  endfunction
endpackage

// File: rtl/pulse_train_sequencer_if.sv
// pulse_train_sequencer_if: LA control inputs and pulse/status outputs of the sequencer
interface pulse_train_sequencer_if #(parameter int NUM_W = 8);
  logic [4:0]       la_data_in;
  logic [4:0]       la_oenb;
  logic             pulse_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [NUM_W-1:0] remain_o;
  modport master(output la_data_in, la_oenb, input pulse_o, busy_o, done_o, err_o, remain_o);
  modport slave(input la_data_in, la_oenb, output pulse_o, busy_o, done_o, err_o, remain_o);
endinterface

// File: rtl/pulse_train_sequencer_la_edge_det.sv
// la_edge_det: masks one LA bit with its output-enable-bar and strobes on its rising edge
module la_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  input  logic oenb_i,
  output logic rise_o
);
  logic eff, prev_q;
  assign eff    = d_i & ~oenb_i;
  assign rise_o = eff & ~prev_q;
  // remember last cycle's effective level
  always_ff @(posedge clk_i) prev_q <= rst_i ? 1'b0 : eff;
endmodule

// File: rtl/pulse_train_sequencer.sv
// pulse_train_sequencer: serially loaded pulse-train generator driven by LA bits; PULSE_SEQ_CONT_EN enables continuous mode
module pulse_train_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  pulse_train_sequencer_if.slave la_if
);
  localparam int SR_W = sr_width(CNT_W, NUM_W);
  logic             shift_rise, start_rise, data_eff, abort_eff, cont_in, cont_act, cfg_ok, load;
  logic [SR_W-1:0]  sr_q;
  logic [CNT_W-1:0] cfg_per, cfg_high, per_q, high_q, cnt_q, cnt_d;
  logic [NUM_W-1:0] cfg_cnt, remain_q, remain_d;
  logic             err_q, err_d, done_q, done_d;
  state_e           state_q, state_d;

  la_edge_det u_shift (.clk_i(wb_clk_i), .rst_i(wb_rst_i), .d_i(la_if.la_data_in[SHIFT]),
                       .oenb_i(la_if.la_oenb[SHIFT]), .rise_o(shift_rise));
  la_edge_det u_start (.clk_i(wb_clk_i), .rst_i(wb_rst_i), .d_i(la_if.la_data_in[START]),
                       .oenb_i(la_if.la_oenb[START]), .rise_o(start_rise));

  assign data_eff  = la_if.la_data_in[DATA] & ~la_if.la_oenb[DATA];
  assign abort_eff = la_if.la_data_in[ABORT] & ~la_if.la_oenb[ABORT];
  assign cfg_per   = sr_q[period_lsb(CNT_W, NUM_W) +: CNT_W];
  assign cfg_high  = sr_q[high_lsb(NUM_W) +: CNT_W];
  assign cfg_cnt   = sr_q[COUNT_LSB +: NUM_W];
  assign cfg_ok    = cfg_high != '0 && cfg_per > cfg_high && (cfg_cnt != '0 || cont_in);

`ifdef PULSE_SEQ_CONT_EN
  logic cont_q;
  assign cont_in  = la_if.la_data_in[CONT] & ~la_if.la_oenb[CONT];
  assign cont_act = cont_q;
  // continuous mode is fixed for the whole run at start
  always_ff @(posedge wb_clk_i) cont_q <= wb_rst_i ? 1'b0 : load ? cont_in : cont_q;
`else
  logic unused_cont;
  assign unused_cont = la_if.la_data_in[CONT] ^ la_if.la_oenb[CONT];
  assign cont_in     = 1'b0;
  assign cont_act    = 1'b0;
`endif

  // config shift register, independent of any running train
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) sr_q <= '0;
    else if (shift_rise) sr_q <= {sr_q[SR_W-2:0], data_eff};
  end

  // next state, phase counter, remaining count and status
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1);
    remain_d = remain_q;
    err_d    = err_q;
    done_d   = 1'b0;
    load     = 1'b0;
    case (state_q)
      IDLE: if (start_rise) begin
        err_d = ~cfg_ok;
        if (cfg_ok) begin
          load     = 1'b1;
          state_d  = HIGH;
          cnt_d    = cfg_high - CNT_W'(1);
          remain_d = cfg_cnt;
        end
      end
      HIGH: if (cnt_q == '0) begin
        state_d = LOW;
        cnt_d   = per_q - high_q - CNT_W'(1);
      end
      LOW: if (cnt_q == '0) begin
        if (remain_q > NUM_W'(1) || cont_act) begin
          state_d  = HIGH;
          cnt_d    = high_q - CNT_W'(1);
          remain_d = cont_act ? remain_q : remain_q - NUM_W'(1);
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_eff) begin
      state_d  = IDLE;
      cnt_d    = cnt_q;
      remain_d = remain_q;
      err_d    = err_q;
      done_d   = 1'b0;
      load     = 1'b0;
    end
  end

  // state and datapath registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      remain_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      per_q    <= '0;
      high_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      remain_q <= remain_d;
      err_q    <= err_d;
      done_q   <= done_d;
      per_q    <= load ? cfg_per : per_q;
      high_q   <= load ? cfg_high : high_q;
    end
  end

  assign la_if.pulse_o  = state_q == HIGH;
  assign la_if.busy_o   = state_q != IDLE;
  assign la_if.done_o   = done_q;
  assign la_if.err_o    = err_q;
  assign la_if.remain_o = remain_q;
endmodule

// File: tb/tb_pulse_train_sequencer.sv
// tb_pulse_train_sequencer: directed checks of config load, run timing, abort, masking and reset
module tb_pulse_train_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  pulse_train_sequencer_if #(.NUM_W(8)) bus ();
  pulse_train_sequencer #(.CNT_W(16), .NUM_W(8)) dut (.wb_clk_i(clk), .wb_rst_i(rst), .la_if(bus));

  always #5 clk = ~clk;

  typedef struct {
    int per;
    int high;
    int cnt;
    int err;
    int hi;
    int len;
  } vec_t;
  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] per, input logic [15:0] high, input logic [7:0] cnt);
    logic [39:0] w;
    w = {per, high, cnt};
    for (int i = 39; i >= 0; i--) begin
      bus.la_data_in[0] = w[i];
      bus.la_data_in[1] = 1'b1;
      step();
      bus.la_data_in[1] = 1'b0;
      step();
    end
  endtask

  task automatic start();
    bus.la_data_in[2] = 1'b1;
    step();
    bus.la_data_in[2] = 1'b0;
  endtask

  task automatic abort();
    bus.la_data_in[3] = 1'b1;
    step();
    bus.la_data_in[3] = 1'b0;
  endtask

  task automatic measure(output int hi, output int len);
    int guard;
    guard = 0;
    hi    = 0;
    len   = 0;
    while (!bus.done_o && guard < 3000) begin
      if (bus.pulse_o) hi++;
      if (bus.busy_o) len++;
      step();
      guard++;
    end
    chk("run_terminated", int'(guard < 3000), 1);
    chk("busy_at_done", bus.busy_o, 0);
  endtask

  initial begin
    int hi, len, k, bad, t;
    logic pp;
    vecs[0] = '{10, 3, 4, 0, 12, 40};
    vecs[1] = '{5, 5, 1, 1, 0, 0};
    vecs[2] = '{2, 1, 1, 0, 1, 2};
    vecs[3] = '{4, 0, 2, 1, 0, 0};
    vecs[4] = '{3, 2, 3, 0, 6, 9};
    vecs[5] = '{6, 1, 0, 1, 0, 0};
    vecs[6] = '{5, 6, 2, 1, 0, 0};
    vecs[7] = '{7, 6, 2, 0, 12, 14};
    bus.la_data_in = '0;
    bus.la_oenb    = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_pulse", bus.pulse_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_remain", bus.remain_o, 0);

    for (int v = 0; v < 8; v++) begin
      load(16'(vecs[v].per), 16'(vecs[v].high), 8'(vecs[v].cnt));
      start();
      chk($sformatf("v%0d_err", v), bus.err_o, vecs[v].err);
      chk($sformatf("v%0d_busy", v), bus.busy_o, 1 - vecs[v].err);
      if (vecs[v].err == 0) begin
        measure(hi, len);
        chk($sformatf("v%0d_high_cycles", v), hi, vecs[v].hi);
        chk($sformatf("v%0d_run_cycles", v), len, vecs[v].len);
      end
    end

    load(16'd10, 16'd3, 8'd4);
    start();
    k   = 0;
    bad = 0;
    pp  = 1'b0;
    for (int c = 1; c <= 42; c++) begin
      if (bus.pulse_o && !pp) begin
        chk("rise_time", c, 1 + 10 * k);
        chk("rise_remain", bus.remain_o, 4 - k);
        k++;
      end
      pp = bus.pulse_o;
      if (c == 41) begin
        chk("done_at_41", bus.done_o, 1);
        chk("busy_at_41", bus.busy_o, 0);
      end else if (bus.done_o) bad++;
      step();
    end
    chk("rise_count", k, 4);
    chk("stray_done", bad, 0);

    load(16'd10, 16'd3, 8'd4);
    start();
    for (int c = 1; c < 12; c++) step();
    chk("pre_abort_pulse", bus.pulse_o, 1);
    abort();
    chk("abort_pulse", bus.pulse_o, 0);
    chk("abort_busy", bus.busy_o, 0);
    chk("abort_done", bus.done_o, 0);
    chk("abort_remain", bus.remain_o, 3);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      if (bus.done_o || bus.busy_o) bad++;
      step();
    end
    chk("abort_quiet", bad, 0);

    bus.la_data_in[3] = 1'b1;
    bus.la_data_in[2] = 1'b1;
    step();
    chk("abort_beats_start", bus.busy_o, 0);
    bus.la_data_in[3] = 1'b0;
    bus.la_data_in[2] = 1'b0;
    step();
    start();
    chk("start_after_abort", bus.busy_o, 1);
    abort();

    load(16'd10, 16'd3, 8'd10);
    start();
    load(16'd20, 16'd5, 8'd1);
    t = 81;
    while (!bus.done_o && t < 200) begin
      step();
      t++;
    end
    chk("reload_done_time", t, 101);
    start();
    measure(hi, len);
    chk("reload_next_high", hi, 5);
    chk("reload_next_len", len, 20);

    load(16'd10, 16'd3, 8'd4);
    start();
    for (int c = 0; c < 5; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrun_rst_pulse", bus.pulse_o, 0);
    chk("midrun_rst_busy", bus.busy_o, 0);
    chk("midrun_rst_remain", bus.remain_o, 0);
    start();
    chk("rst_clears_sr_err", bus.err_o, 1);
    chk("rst_clears_sr_busy", bus.busy_o, 0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.la_oenb = 5'h1F;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      bus.la_data_in = 5'($urandom);
      step();
      if (bus.pulse_o || bus.busy_o || bus.done_o || bus.err_o || bus.remain_o != 0) bad++;
    end
    chk("masked_outputs", bad, 0);
    bus.la_data_in = '0;
    step();
    bus.la_oenb = '0;
    step();
    start();
    chk("masked_no_shift_err", bus.err_o, 1);
    chk("masked_no_shift_busy", bus.busy_o, 0);

`ifdef PULSE_SEQ_CONT_EN
    load(16'd4, 16'd1, 8'd0);
    bus.la_data_in[4] = 1'b1;
    start();
    bus.la_data_in[4] = 1'b0;
    hi  = 0;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.pulse_o) hi++;
      if (bus.done_o || !bus.busy_o) bad++;
      step();
    end
    chk("cont_pulses", hi, 25);
    chk("cont_no_done", bad, 0);
    abort();
    chk("cont_abort_busy", bus.busy_o, 0);
    chk("cont_abort_done", bus.done_o, 0);
`else
    load(16'd4, 16'd1, 8'd0);
    bus.la_data_in[4] = 1'b1;
    start();
    bus.la_data_in[4] = 1'b0;
    chk("nocont_err", bus.err_o, 1);
    chk("nocont_busy", bus.busy_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
